// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the datapath packages.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath types for the instruction-fetch stage.
package dp_types_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries.
// Ports:
//   CLK, nRST            clock, async active-low reset
//   clear                drop all entries (wins over push/pop)
//   push, push_instr/pc  enqueue one entry (ignored when full and not popping)
//   pop                  dequeue head (ignored when empty)
//   head_instr/pc        head entry, zero when empty
//   count                occupancy
module fetch_fifo
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   clear,
    input  logic                   push,
    input  logic [31:0]            push_instr,
    input  logic [31:0]            push_pc,
    input  logic                   pop,
    output logic [31:0]            head_instr,
    output logic [31:0]            head_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic do_push, do_pop;
    fetch_entry_t head_entry;

    assign do_pop  = pop && (count_q != '0);
    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign do_push = push && ((count_q < Full) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PtrW'(1);
            if (do_pop)  head_d = head_q + PtrW'(1);
            if (do_push && !do_pop)      count_d = count_q + CntW'(1);
            else if (do_pop && !do_push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge CLK) begin
        if (do_push && !clear) begin
            mem_q[tail_q] <= '{instr: push_instr, pc: push_pc};
        end
    end

    assign head_entry = (count_q != '0) ? mem_q[head_q] : '0;
    assign head_instr = head_entry.instr;
    assign head_pc    = head_entry.pc;
    assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues icache reads and buffers
// fetched instructions ahead of the IF/ID latch.
// Ports:
//   CLK, nRST            clock, async active-low reset
//   ihit, imemload       icache response valid / data
//   imemREN, imemaddr    icache request / address
//   deq_en               pop the head entry this cycle
//   redirect, redirect_pc  refetch from corrected target
//   halt                 stop fetching until reset
//   q_valid/instr/pc/npc head entry (empty values when queue is empty)
//   q_count              occupancy
module fetch_queue
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic [31:0]            imemload,
    output logic                   imemREN,
    output logic [31:0]            imemaddr,
    input  logic                   deq_en,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   halt,
    output logic                   q_valid,
    output logic [31:0]            q_instr,
    output logic [31:0]            q_pc,
    output logic [31:0]            q_npc,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    fetch_state_t state_q, state_d;
    word_t fetch_pc_q, fetch_pc_d;
    word_t target_q, target_d;
    word_t redir_pc;
    logic ren, push, pop, clear;

    assign redir_pc = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        ren        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            FETCH: begin
                ren = (q_count < Full);
                if (halt) begin
                    state_d = HALTED;
                    clear   = 1'b1;
                end else if (redirect) begin
                    clear = 1'b1;
                    if (ren && !ihit) begin
                        // Miss in flight: keep the address stable and park the target.
                        state_d  = SQUASH;
                        target_d = redir_pc;
                    end else begin
                        fetch_pc_d = redir_pc;
                    end
                end else begin
                    pop = deq_en && q_valid;
                    if (ren && ihit) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            SQUASH: begin
                ren = 1'b1;
                if (halt) begin
                    state_d = HALTED;
                    clear   = 1'b1;
                end else begin
                    if (redirect) begin
                        target_d = redir_pc;
                        clear    = 1'b1;
                    end
                    if (ihit) begin
                        state_d    = FETCH;
                        fetch_pc_d = redirect ? redir_pc : target_q;
                    end
                end
            end
            HALTED: begin
                clear = 1'b1;
            end
            default: begin
                state_d = HALTED;
                clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            fetch_pc_q <= PC_INIT;
            target_q   <= PC_INIT;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .nRST       (nRST),
        .clear      (clear),
        .push       (push),
        .push_instr (imemload),
        .push_pc    (fetch_pc_q),
        .pop        (pop),
        .head_instr (q_instr),
        .head_pc    (q_pc),
        .count      (q_count)
    );

    // Request is suppressed while reset is held so the cache sees no read.
    assign imemREN  = ren && nRST;
    assign imemaddr = fetch_pc_q;
    assign q_valid  = (q_count != '0);
    assign q_npc    = q_pc + 32'd4;

endmodule
